// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide unit for the EX stage.
// One shift-add (MUL) or restoring-subtract (DIV) step per clock; stalls the pipe while busy.
module muldiv_sequencer #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [5:0]  FUNC_MUL = 6'b000010,
    parameter logic [5:0]  FUNC_DIV = 6'b000001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic [2:0]       flag
);

    localparam int unsigned CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0]  FLAG_NONE = 3'b000;
    localparam logic [2:0]  FLAG_EXC  = 3'b010;
    localparam logic [2:0]  FLAG_OVF  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             op_div;
    logic [WIDTH-1:0] operand;   // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] acc_hi;    // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend bits shifting into quotient

    logic             is_muldiv;
    logic             is_div_req;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;

    assign is_div_req = (func == FUNC_DIV);
    assign is_muldiv  = (func == FUNC_MUL) || is_div_req;
    assign stall      = (state == BUSY) || ((state == IDLE) && start && is_muldiv);

    // One iteration of the selected algorithm on the current accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, operand};
        hi_nx     = mul_sum[WIDTH:1];
        lo_nx     = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (op_div) begin
            if (!div_trial[WIDTH]) begin
                hi_nx = div_trial[WIDTH-1:0];
                lo_nx = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                lo_nx = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            op_div    <= 1'b0;
            operand   <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            flag      <= FLAG_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_muldiv) begin
                        op_div    <= is_div_req;
                        count     <= CNT_W'(WIDTH - 1);
                        acc_hi    <= '0;
                        busy      <= 1'b1;
                        result    <= '0;
                        remainder <= '0;
                        flag      <= FLAG_NONE;
                        if (is_div_req) begin
                            operand <= data_b;
                            acc_lo  <= data_a;
                            // Divide by zero skips the iterations entirely.
                            if (data_b == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                                flag  <= FLAG_EXC;
                            end else begin
                                state <= BUSY;
                            end
                        end else begin
                            operand <= data_a;
                            acc_lo  <= data_b;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= hi_nx;
                    acc_lo <= lo_nx;
                    count  <= count - CNT_W'(1);
                    if (count == '0) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        result    <= lo_nx;
                        remainder <= hi_nx;
                        flag      <= (!op_div && (hi_nx != '0)) ? FLAG_OVF : FLAG_NONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int unsigned WIDTH    = 32;
    localparam logic [5:0]  FUNC_MUL = 6'b000010;
    localparam logic [5:0]  FUNC_DIV = 6'b000001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  func = '0;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [31:0] remainder;
    logic [2:0]  flag;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(
        .WIDTH    (WIDTH),
        .FUNC_MUL (FUNC_MUL),
        .FUNC_DIV (FUNC_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .func      (func),
        .data_a    (data_a),
        .data_b    (data_b),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .flag      (flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic.
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [31:0] rem, output logic [2:0] fl);
        logic [63:0] p;
        if (f == FUNC_MUL) begin
            p   = 64'(a) * 64'(b);
            r   = p[31:0];
            rem = p[63:32];
            fl  = (p[63:32] != 32'd0) ? 3'b011 : 3'b000;
        end else if (b == 32'd0) begin
            r   = '0;
            rem = '0;
            fl  = 3'b010;
        end else begin
            r   = a / b;
            rem = a % b;
            fl  = 3'b000;
        end
    endtask

    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er, erem, gr, grem;
        logic [2:0]  efl, gfl;
        int          exp_lat, done_edge, done_cnt, busy_cnt;
        model(f, a, b, er, erem, efl);
        exp_lat   = (f == FUNC_DIV && b == 32'd0) ? 1 : int'(WIDTH) + 1;
        done_edge = 0;
        done_cnt  = 0;
        busy_cnt  = 0;
        gr        = '0;
        grem      = '0;
        gfl       = '0;
        @(negedge clk);
        start  = 1'b1;
        func   = f;
        data_a = a;
        data_b = b;
        #1;
        check("stall_req", 64'(stall), 64'd1);
        for (int e = 1; e <= int'(WIDTH) + 8; e++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_edge = e;
                    gr        = result;
                    grem      = remainder;
                    gfl       = flag;
                end
            end
            if (e == 1) begin
                start  = 1'b0;
                data_a = $urandom;
                data_b = $urandom;
                if (exp_lat > 1) begin
                    check("clr_res", {remainder, result}, 64'd0);
                    check("clr_flag", 64'(flag), 64'd0);
                end
            end
            // New request in the middle of an operation must be dropped.
            if (e == 3 && exp_lat > 1) begin
                check("stall_busy", 64'(stall), 64'd1);
                start  = 1'b1;
                func   = FUNC_MUL;
                data_a = $urandom;
                data_b = $urandom;
            end
            if (e == 4) start = 1'b0;
            // Request arriving while done is high is also dropped.
            if (e == exp_lat) begin
                start = 1'b1;
                func  = f;
            end
            if (e == exp_lat + 1) start = 1'b0;
        end
        check("done_edge", 64'(done_edge), 64'(exp_lat));
        check("done_cnt", 64'(done_cnt), 64'd1);
        check("busy_cnt", 64'(busy_cnt), 64'(exp_lat));
        check("result", 64'(gr), 64'(er));
        check("remainder", 64'(grem), 64'(erem));
        check("flag", 64'(gfl), 64'(efl));
        check("hold", {remainder, result}, {erem, er});
    endtask

    initial begin
        int bad;
        int sel;
        logic [5:0]  rf;
        logic [31:0] ra, rb;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out", {remainder, result}, 64'd0);
        check("rst_flag", 64'(flag), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(FUNC_MUL, 32'd7, 32'd6);
        do_op(FUNC_MUL, 32'h0001_0000, 32'h0001_0000);
        do_op(FUNC_DIV, 32'd100, 32'd7);
        do_op(FUNC_DIV, 32'hFFFF_FFFF, 32'd1);
        do_op(FUNC_DIV, 32'd5, 32'd0);

        // Non-MUL/DIV func must never stall or start.
        @(negedge clk);
        start  = 1'b1;
        func   = 6'b100000;
        data_a = $urandom;
        data_b = $urandom;
        #1;
        check("nop_stall", 64'(stall), 64'd0);
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (busy || done || stall) bad++;
        end
        check("nop_quiet", 64'(bad), 64'd0);
        start = 1'b0;

        // Reset part-way through a multiply aborts it silently.
        @(negedge clk);
        start  = 1'b1;
        func   = FUNC_MUL;
        data_a = 32'd7;
        data_b = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_out", {remainder, result}, 64'd0);
        check("abort_flag", 64'(flag), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) bad++;
        end
        check("abort_quiet", 64'(bad), 64'd0);
        do_op(FUNC_DIV, 32'd9, 32'd3);

        for (int i = 0; i < 15; i++) begin
            rf  = ($urandom_range(0, 1) == 0) ? FUNC_MUL : FUNC_DIV;
            ra  = $urandom;
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) rb = 32'($urandom_range(1, 255));
            else               rb = $urandom;
            do_op(rf, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
